// File: rtl/b16_bus_pkg.sv
// Shared types and limits for the b16 memory-port arbiter and its helpers.
package b16_bus_pkg;

   localparam int CW_DEF   = 4;
   localparam int MAX_WAIT = 15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CPU  = 2'd1,
      HOST = 2'd2
   } owner_e;

endpackage

// File: rtl/bus_wait_cnt.sv
// Wait-state down-counter: loads the wait count at slot start, decrements each
// slot cycle and flags the final cycle combinationally (also on the load cycle).
module bus_wait_cnt #(
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_i,
   input  logic          busy_i,
   input  logic          clr_i,
   input  logic [CW-1:0] wait_i,
   output logic          final_o
);

   logic [CW-1:0] cnt_q, cnt_d, cur;

   always_comb begin
      cur     = load_i ? wait_i : cnt_q;
      final_o = (cur == '0);
      cnt_d   = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (load_i || busy_i)
         cnt_d = final_o ? '0 : cur - CW'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/b16_bus_arbiter.sv
// Shares the b16 memory port between CPU and host with WAIT wait states per access.
// ARB_RR_EN selects round-robin on contention; otherwise the host always wins.
module b16_bus_arbiter
   import b16_bus_pkg::*;
#(
   parameter int l    = 16,
   parameter int WAIT = 1,
   parameter int CW   = CW_DEF
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         dbg_run,
   output logic         cpu_run,
   input  logic [l-1:0] cpu_addr,
   input  logic         cpu_rd,
   input  logic [1:0]   cpu_wr,
   input  logic [l-1:0] cpu_dout,
   output logic [l-1:0] cpu_din,
   input  logic         h_req,
   input  logic [1:0]   h_we,
   input  logic [l-1:0] h_addr,
   input  logic [l-1:0] h_wdata,
   output logic         h_ack,
   output logic [l-1:0] h_rdata,
   output logic [l-1:0] mem_addr,
   output logic         mem_rd,
   output logic [1:0]   mem_wr,
   output logic [l-1:0] mem_wdata,
   input  logic [l-1:0] mem_rdata
);

   localparam logic [CW-1:0] WAIT_L = CW'(WAIT);

   owner_e         state_q, state_d;
   logic           h_ack_q, h_ack_d;
   logic [l-1:0]   h_rdata_q, h_rdata_d;
   logic           cpu_want, host_want, in_idle;
   logic           grant_cpu, grant_host, own_cpu, own_host;
   logic           abort, cnt_final, slot_final;

   assign cpu_want  = dbg_run & (cpu_rd | (|cpu_wr));
   assign host_want = h_req & ~h_ack_q;
   assign in_idle   = reset & (state_q == IDLE);

`ifdef ARB_RR_EN
   owner_e last_q, last_d;
   assign grant_host = in_idle & host_want & (~cpu_want | (last_q == CPU));
`else
   assign grant_host = in_idle & host_want;
`endif
   assign grant_cpu  = in_idle & cpu_want & ~grant_host;

   // A CPU slot dies as soon as the debugger halts; the host slot always completes.
   assign abort      = (state_q == CPU) & ~dbg_run;
   assign own_cpu    = grant_cpu  | ((state_q == CPU) & dbg_run);
   assign own_host   = grant_host | (state_q == HOST);
   assign slot_final = (own_cpu | own_host) & cnt_final;

   bus_wait_cnt #(.CW(CW)) u_wait_cnt (
      .clk     (clk),
      .reset   (reset),
      .load_i  (grant_cpu | grant_host),
      .busy_i  (state_q != IDLE),
      .clr_i   (abort),
      .wait_i  (WAIT_L),
      .final_o (cnt_final)
   );

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_rd    = 1'b0;
      mem_wr    = 2'b00;
      if (own_cpu) begin
         mem_addr  = cpu_addr;
         mem_wdata = cpu_dout;
         mem_rd    = cpu_rd;
         if (slot_final) mem_wr = cpu_wr;
      end else if (own_host) begin
         mem_addr  = h_addr;
         mem_wdata = h_wdata;
         mem_rd    = (h_we == 2'b00);
         if (slot_final) mem_wr = h_we;
      end
   end

   assign cpu_run = reset & dbg_run & (~cpu_want | (own_cpu & slot_final));
   assign cpu_din = mem_rdata;
   assign h_ack   = h_ack_q;
   assign h_rdata = h_rdata_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (grant_cpu && !cnt_final)       state_d = CPU;
            else if (grant_host && !cnt_final) state_d = HOST;
         end
         CPU:     if (abort || cnt_final) state_d = IDLE;
         HOST:    if (cnt_final)          state_d = IDLE;
         default: state_d = IDLE;
      endcase
      h_ack_d   = own_host & slot_final;
      h_rdata_d = h_ack_d ? mem_rdata : h_rdata_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         h_ack_q   <= 1'b0;
         h_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         h_ack_q   <= h_ack_d;
         h_rdata_q <= h_rdata_d;
      end
   end

`ifdef ARB_RR_EN
   always_comb begin
      last_d = last_q;
      if (slot_final) last_d = own_cpu ? CPU : HOST;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) last_q <= HOST;
      else        last_q <= last_d;
   end
`endif

endmodule

// File: tb/tb_b16_bus_arbiter.sv
// Scoreboard bench for b16_bus_arbiter: main DUT with WAIT=2, side DUT with WAIT=0.
module tb_b16_bus_arbiter;

   localparam logic [15:0] K = 16'hA5C3;

   logic        clk = 1'b0;
   logic        reset, dbg_run, cpu_run, cpu_rd, h_req, h_ack, mem_rd;
   logic [1:0]  cpu_wr, h_we, mem_wr;
   logic [15:0] cpu_addr, cpu_dout, cpu_din, h_addr, h_wdata, h_rdata;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;

   logic        z_cpu_run, z_h_ack, z_mem_rd;
   logic [1:0]  z_mem_wr;
   logic [15:0] z_cpu_din, z_h_rdata, z_mem_addr, z_mem_wdata, z_mem_rdata;

   assign mem_rdata   = mem_addr ^ K;
   assign z_mem_rdata = z_mem_addr ^ K;

   always #5 clk = ~clk;

   b16_bus_arbiter #(.l(16), .WAIT(2), .CW(4)) u_dut (
      .clk(clk), .reset(reset), .dbg_run(dbg_run), .cpu_run(cpu_run),
      .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_dout(cpu_dout),
      .cpu_din(cpu_din), .h_req(h_req), .h_we(h_we), .h_addr(h_addr),
      .h_wdata(h_wdata), .h_ack(h_ack), .h_rdata(h_rdata), .mem_addr(mem_addr),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   b16_bus_arbiter #(.l(16), .WAIT(0), .CW(4)) u_dut_w0 (
      .clk(clk), .reset(reset), .dbg_run(dbg_run), .cpu_run(z_cpu_run),
      .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_dout(cpu_dout),
      .cpu_din(z_cpu_din), .h_req(1'b0), .h_we(2'b00), .h_addr(16'h0000),
      .h_wdata(16'h0000), .h_ack(z_h_ack), .h_rdata(z_h_rdata), .mem_addr(z_mem_addr),
      .mem_rd(z_mem_rd), .mem_wr(z_mem_wr), .mem_wdata(z_mem_wdata), .mem_rdata(z_mem_rdata)
   );

   typedef struct { logic [15:0] a; logic [15:0] din; int stall; int rdlen; } cpu_exp_t;
   typedef struct { logic [15:0] a; logic [1:0] wr; logic [15:0] d; } wr_exp_t;
   typedef struct { logic [15:0] rd; int cyc; } ack_exp_t;

   cpu_exp_t cpu_q[$];
   wr_exp_t  wr_q[$];
   ack_exp_t ack_q[$];

   int nvec = 0, nerr = 0, cyc = 0, stall = 0, rdlen = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: pops expectations whenever the DUT completes a CPU access, writes, or acks.
   always @(negedge clk) begin
      if (!reset) begin
         stall = 0;
         rdlen = 0;
      end else begin : mon
         logic     cw;
         cpu_exp_t ce;
         wr_exp_t  we;
         ack_exp_t ae;
         cw = dbg_run & (cpu_rd | (|cpu_wr));
         if (mem_rd) rdlen++; else rdlen = 0;
         if (cw && cpu_run) begin
            if (cpu_q.size() == 0) chk("cpu_unexpected_completion", 1, 0);
            else begin
               ce = cpu_q.pop_front();
               chk("cpu_stall_cycles", stall, ce.stall);
               chk("cpu_mem_addr", mem_addr, ce.a);
               chk("cpu_din", cpu_din, ce.din);
               chk("cpu_mem_rd_cycles", rdlen, ce.rdlen);
            end
            stall = 0;
            rdlen = 0;
         end else if (cw) stall++;
         else stall = 0;
         if (mem_wr != 2'b00) begin
            if (wr_q.size() == 0) chk("unexpected_write", {mem_addr, 14'd0, mem_wr}, 0);
            else begin
               we = wr_q.pop_front();
               chk("wr_addr", mem_addr, we.a);
               chk("wr_strobe", mem_wr, we.wr);
               chk("wr_data", mem_wdata, we.d);
            end
         end
         if (h_ack) begin
            if (ack_q.size() == 0) chk("unexpected_h_ack", 1, 0);
            else begin
               ae = ack_q.pop_front();
               chk("h_rdata", h_rdata, ae.rd);
               chk("h_ack_cycle", cyc, ae.cyc);
            end
         end
         chk("w0_cpu_run", z_cpu_run, dbg_run);
         chk("w0_mem_addr", z_mem_addr, cw ? cpu_addr : 16'h0000);
         chk("w0_mem_rd", z_mem_rd, cw & cpu_rd);
      end
   end

   // Call just after a rising edge; returns just after the edge following completion.
   task automatic cpu_xfer(input logic [15:0] a, input logic rd, input logic [1:0] wr,
                           input logic [15:0] d, input int st, input int rl);
      cpu_exp_t ce;
      wr_exp_t  we;
      bit       got = 0;
      ce.a = a; ce.din = a ^ K; ce.stall = st; ce.rdlen = rl;
      cpu_q.push_back(ce);
      if (wr != 2'b00) begin
         we.a = a; we.wr = wr; we.d = d;
         wr_q.push_back(we);
      end
      cpu_addr = a; cpu_rd = rd; cpu_wr = wr; cpu_dout = d;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (cpu_run) begin got = 1; break; end
      end
      chk("cpu_access_completes", got, 1);
      @(posedge clk); #1;
      cpu_rd = 1'b0; cpu_wr = 2'b00;
   endtask

   task automatic host_xfer(input logic [15:0] a, input logic [1:0] we_i,
                            input logic [15:0] d, input int lat);
      ack_exp_t ae;
      wr_exp_t  we;
      bit       got = 0;
      ae.rd = a ^ K; ae.cyc = cyc + lat;
      ack_q.push_back(ae);
      if (we_i != 2'b00) begin
         we.a = a; we.wr = we_i; we.d = d;
         wr_q.push_back(we);
      end
      h_req = 1'b1; h_we = we_i; h_addr = a; h_wdata = d;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (h_ack) begin got = 1; break; end
      end
      chk("host_ack_seen", got, 1);
      @(posedge clk); #1;
      h_req = 1'b0; h_we = 2'b00; h_addr = '0; h_wdata = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; dbg_run = 1'b1;
      cpu_addr = 16'h1111; cpu_rd = 1'b1; cpu_wr = 2'b00; cpu_dout = 16'h2222;
      h_req = 1'b1; h_we = 2'b11; h_addr = 16'h3333; h_wdata = 16'h4444;
      repeat (2) @(negedge clk);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_rd", mem_rd, 0);
      chk("rst_mem_wr", mem_wr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_cpu_run", cpu_run, 0);
      chk("rst_h_ack", h_ack, 0);
      chk("rst_h_rdata", h_rdata, 0);
      cpu_rd = 1'b0; h_req = 1'b0; h_we = 2'b00;
      @(posedge clk); #1 reset = 1'b1;

      cpu_xfer(16'h3FFE, 1'b1, 2'b00, 16'h0000, 2, 3);
      cpu_xfer(16'h0010, 1'b1, 2'b00, 16'h0000, 2, 3);
      cpu_xfer(16'hFFFE, 1'b1, 2'b00, 16'h0000, 2, 3);
      cpu_xfer(16'h8001, 1'b1, 2'b00, 16'h0000, 2, 3);
      cpu_xfer(16'h0200, 1'b0, 2'b01, 16'h55AA, 2, 0);

      fork
         host_xfer(16'h0100, 2'b11, 16'h1234, 3);
         begin
            @(negedge clk); @(negedge clk);
            chk("cpu_run_idle_cpu_during_host", cpu_run, 1);
         end
      join
      host_xfer(16'h0ABC, 2'b00, 16'h0000, 3);
      cpu_xfer(16'h0202, 1'b0, 2'b10, 16'hBEEF, 2, 0);

      // Last owner is the CPU, so the host wins this collision in either build.
      fork
         host_xfer(16'h0300, 2'b11, 16'hCAFE, 3);
         cpu_xfer(16'h0304, 1'b1, 2'b00, 16'h0000, 5, 3);
      join

      host_xfer(16'h0400, 2'b00, 16'h0000, 3);
`ifdef ARB_RR_EN
      fork
         host_xfer(16'h0500, 2'b01, 16'h0077, 6);
         cpu_xfer(16'h0504, 1'b1, 2'b00, 16'h0000, 2, 3);
      join
`else
      fork
         host_xfer(16'h0500, 2'b01, 16'h0077, 3);
         cpu_xfer(16'h0504, 1'b1, 2'b00, 16'h0000, 5, 3);
      join
`endif

      // Debugger halt in the second cycle of a CPU write: no strobe may reach memory.
      cpu_addr = 16'h0600; cpu_wr = 2'b11; cpu_dout = 16'h0F0F;
      @(posedge clk); #1 dbg_run = 1'b0;
      @(posedge clk); #1 cpu_wr = 2'b00; dbg_run = 1'b1;
      cpu_xfer(16'h0600, 1'b0, 2'b11, 16'h0F0F, 2, 0);

      h_addr = 16'h0700; h_we = 2'b11; h_wdata = 16'hDEAD; h_req = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("midrst_mem_addr", mem_addr, 0);
      chk("midrst_mem_rd", mem_rd, 0);
      chk("midrst_mem_wr", mem_wr, 0);
      chk("midrst_mem_wdata", mem_wdata, 0);
      chk("midrst_cpu_run", cpu_run, 0);
      chk("midrst_h_ack", h_ack, 0);
      chk("midrst_h_rdata", h_rdata, 0);
      @(posedge clk); #1 h_req = 1'b0; h_we = 2'b00; h_addr = '0; h_wdata = '0;
      @(posedge clk); #1 reset = 1'b1;
      repeat (4) @(negedge clk);
      @(posedge clk); #1;
      host_xfer(16'h0702, 2'b00, 16'h0000, 3);

      repeat (3) @(negedge clk);
      chk("cpu_queue_drained", cpu_q.size(), 0);
      chk("write_queue_drained", wr_q.size(), 0);
      chk("ack_queue_drained", ack_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
